// File: rtl/mano_pkg.sv
// mano_pkg: shared constants and types for the Mano-style CPU sequencer.
//   - Default widths of the sequence counter, opcode field and IR.
//   - IR field positions for the default IR width (I bit, opcode MSB).
//   - Named indices into the one-hot T (timing) and D (opcode) vectors,
//     so control-logic equations read as T[T2], D[D7] and so on.
//   - Encoding of where the next sequence-counter value comes from.
package mano_pkg;

  localparam int SC_WIDTH_DEF = 4;
  localparam int OP_WIDTH_DEF = 3;
  localparam int IR_WIDTH_DEF = 16;

  // Field positions for the default 16-bit IR.
  localparam int IR_I_BIT  = IR_WIDTH_DEF - 1;
  localparam int IR_OP_MSB = IR_WIDTH_DEF - 2;

  // Timing-signal indices.
  localparam int T0 = 0;
  localparam int T1 = 1;
  localparam int T2 = 2;
  localparam int T3 = 3;
  localparam int T4 = 4;
  localparam int T5 = 5;
  localparam int T6 = 6;
  localparam int T7 = 7;

  // Decoded-opcode indices.
  localparam int D0 = 0;
  localparam int D1 = 1;
  localparam int D2 = 2;
  localparam int D3 = 3;
  localparam int D4 = 4;
  localparam int D5 = 5;
  localparam int D6 = 6;
  localparam int D7 = 7;

  // Source of the next sequence-counter value, in falling priority.
  typedef enum logic [1:0] {
    SC_SRC_HOLD  = 2'd0,  // halted: keep t
    SC_SRC_CLR   = 2'd1,  // end-of-instruction clear
    SC_SRC_RTEND = 2'd2,  // last step of the interrupt cycle
    SC_SRC_INC   = 2'd3   // normal counting
  } sc_src_e;

endpackage

// File: rtl/mano_onehot_dec.sv
// mano_onehot_dec: parametrised binary-to-one-hot decoder.
//   Parameters: N - number of binary input bits.
//   Ports:
//     bin_i    [N-1:0]      binary value
//     onehot_o [2**N-1:0]   line bin_i high, every other line low
// Purely combinational.
module mano_onehot_dec #(
  parameter int N = 3
) (
  input  logic [N-1:0]      bin_i,
  output logic [2**N-1:0]   onehot_o
);

  generate
    for (genvar gi = 0; gi < 2**N; gi++) begin : g_line
      assign onehot_o[gi] = (bin_i == N'(gi));
    end
  endgenerate

endmodule

// File: rtl/mano_seq_ctrl.sv
// mano_seq_ctrl: timing / sequence controller for the Mano-style CPU.
//   Produces the sequence counter t and its one-hot decode T, latches the
//   decoded opcode D and indirect bit i at T2, and keeps the run flag and
//   (optionally) the interrupt-cycle flag r.
//
//   Build option: define SEQ_INTR_EN to enable the interrupt-cycle flag r.
//   Without it r is tied low and IEN/FGI/FGO are ignored (ports remain).
//
//   Ports:
//     CLK     in   system clock, rising edge
//     RST     in   asynchronous active-high reset
//     IN_IR   in   instruction register
//     SC_CLR  in   end-of-instruction clear from the control logic
//     HLT     in   clear run flag (wins over START)
//     START   in   set run flag
//     IEN     in   interrupt enable         (SEQ_INTR_EN only)
//     FGI     in   input flag               (SEQ_INTR_EN only)
//     FGO     in   output flag              (SEQ_INTR_EN only)
//     t       out  sequence-counter value
//     T       out  one-hot decode of t (combinational)
//     D       out  registered one-hot opcode
//     i       out  registered indirect bit
//     r       out  interrupt-cycle flag
//     run     out  run flag (Mano S)
//     sc_ovf  out  sticky counter-wrap flag
module mano_seq_ctrl
  import mano_pkg::*;
#(
  parameter int SC_WIDTH = SC_WIDTH_DEF,
  parameter int OP_WIDTH = OP_WIDTH_DEF,
  parameter int IR_WIDTH = IR_WIDTH_DEF
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [IR_WIDTH-1:0]     IN_IR,
  input  logic                    SC_CLR,
  input  logic                    HLT,
  input  logic                    START,
  input  logic                    IEN,
  input  logic                    FGI,
  input  logic                    FGO,
  output logic [SC_WIDTH-1:0]     t,
  output logic [2**SC_WIDTH-1:0]  T,
  output logic [2**OP_WIDTH-1:0]  D,
  output logic                    i,
  output logic                    r,
  output logic                    run,
  output logic                    sc_ovf
);

  logic [SC_WIDTH-1:0]    sc_q, sc_d;
  logic                   ovf_q, ovf_d;
  logic                   run_q, run_d;
  logic [2**OP_WIDTH-1:0] d_q, d_d;
  logic                   i_q, i_d;
  logic                   r_q;
  logic [2**OP_WIDTH-1:0] op_onehot;
  logic                   dec_en;
  sc_src_e                sc_src;

  // Timing lines straight from the counter, no register stage.
  mano_onehot_dec #(.N(SC_WIDTH)) u_t_dec (
    .bin_i    (sc_q),
    .onehot_o (T)
  );

  // Opcode decode ahead of the D register.
  mano_onehot_dec #(.N(OP_WIDTH)) u_op_dec (
    .bin_i    (IN_IR[IR_WIDTH-2 -: OP_WIDTH]),
    .onehot_o (op_onehot)
  );

  // Address bits of the IR are not used here.
  wire unused_ir = &{1'b0, IN_IR[IR_WIDTH-OP_WIDTH-2:0]};

  // Next-t source: clear beats end-of-interrupt beats counting.
  always_comb begin
    sc_src = SC_SRC_HOLD;
    if (SC_CLR)
      sc_src = SC_SRC_CLR;
    else if (r_q && T[T2])
      sc_src = SC_SRC_RTEND;
    else if (run_q)
      sc_src = SC_SRC_INC;
  end

  always_comb begin
    sc_d  = sc_q;
    ovf_d = ovf_q;
    unique case (sc_src)
      SC_SRC_CLR,
      SC_SRC_RTEND: sc_d = '0;
      SC_SRC_INC: begin
        sc_d = sc_q + SC_WIDTH'(1);
        // Stepping off all-ones means the control logic never cleared t.
        if (&sc_q)
          ovf_d = 1'b1;
      end
      SC_SRC_HOLD:  sc_d = sc_q;
    endcase
  end

  // Fetch/decode happens only at T2 of a normal (non-interrupt) cycle.
  assign dec_en = T[T2] && !r_q && run_q;

  always_comb begin
    d_d = d_q;
    i_d = i_q;
    if (dec_en) begin
      d_d = op_onehot;
      i_d = IN_IR[IR_WIDTH-1];
    end
  end

  always_comb begin
    run_d = run_q;
    if (HLT)
      run_d = 1'b0;
    else if (START)
      run_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sc_q  <= '0;
      ovf_q <= 1'b0;
      run_q <= 1'b1;
      d_q   <= '0;
      i_q   <= 1'b0;
    end else begin
      sc_q  <= sc_d;
      ovf_q <= ovf_d;
      run_q <= run_d;
      d_q   <= d_d;
      i_q   <= i_d;
    end
  end

`ifdef SEQ_INTR_EN
  logic r_d;

  // Enter the interrupt cycle only from T3 onward of a running
  // instruction, so fetch/decode (T0..T2) is never split.
  always_comb begin
    r_d = r_q;
    if (sc_src == SC_SRC_RTEND)
      r_d = 1'b0;
    else if (run_q && !r_q && !(T[T0] || T[T1] || T[T2]) && IEN && (FGI || FGO))
      r_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      r_q <= 1'b0;
    else
      r_q <= r_d;
  end
`else
  assign r_q = 1'b0;
  wire unused_intr = &{1'b0, IEN, FGI, FGO};
`endif

  assign t      = sc_q;
  assign D      = d_q;
  assign i      = i_q;
  assign r      = r_q;
  assign run    = run_q;
  assign sc_ovf = ovf_q;

endmodule

// File: doc/mano_seq_ctrl.md
Name: mano_seq_ctrl

Overview:
Parametrised timing/sequence controller for the Mano-style CPU.
- Generates the sequence-counter value and one-hot timing signals T.
- Latches the decoded opcode D and the indirect bit I at T2.
- Manages the run/halt flip-flop and, optionally, the interrupt-cycle flip-flop R.
- Sits between the IR and the control-logic gates, which feed back the end-of-instruction clear.

Parameters:
- SC_WIDTH, 4, sequence-counter width; T has 2**SC_WIDTH lines.
- OP_WIDTH, 3, opcode field width; D has 2**OP_WIDTH lines.
- IR_WIDTH, 16, instruction-register width; I is bit IR_WIDTH-1 and the opcode is the OP_WIDTH bits directly below it.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- IN_IR  in  IR_WIDTH  current instruction register.
- SC_CLR  in  1  end-of-instruction clear from control logic.
- HLT  in  1  clears the run flag.
- START  in  1  sets the run flag.
- IEN  in  1  interrupt enable (used only with SEQ_INTR_EN).
- FGI  in  1  input flag (used only with SEQ_INTR_EN).
- FGO  in  1  output flag (used only with SEQ_INTR_EN).
- t  out  SC_WIDTH  sequence-counter value.
- T  out  2**SC_WIDTH  one-hot decode of t (combinational).
- D  out  2**OP_WIDTH  registered one-hot opcode.
- i  out  1  registered indirect bit.
- r  out  1  interrupt-cycle flag.
- run  out  1  run flag (Mano S).
- sc_ovf  out  1  sticky wrap-error flag.

Behaviour:
- Reset (async, RST=1): t=0, D=0 (all lines low), i=0, r=0, run=1, sc_ovf=0.
- T[k]=1 exactly when t==k. Zero latency from t.
- Next-t priority at each rising edge:
  1. SC_CLR=1 -> t<=0. This applies even when run=0.
  2. Else r=1 and t==2 -> t<=0 and r<=0 (end of interrupt cycle RT0..RT2).
  3. Else run=1 -> t<=t+1, modulo 2**SC_WIDTH.
  4. Else hold t.
- Wrap: an increment from all-ones to 0 sets sc_ovf. sc_ovf stays set until RST. t still wraps to 0.
- Decode: at an edge with t==2, r==0 and run==1:
  - D <= one-hot of IN_IR[IR_WIDTH-2 -: OP_WIDTH].
  - i <= IN_IR[IR_WIDTH-1].
  - Otherwise D and i hold. They are never updated during an interrupt cycle.
- Run flag: HLT=1 -> run<=0. Else START=1 -> run<=1. Else hold. If both are asserted, HLT wins.
- Halted (run=0): t frozen except for SC_CLR; D and i hold; r is not set.
- Reset mid-instruction: every output returns immediately to its reset value. Counting resumes at t=0 on the first edge after RST deasserts.

Optional Feature:
Macro: SEQ_INTR_EN.
- Defined:
  - r<=1 at an edge where run=1, r=0, t is not 0, 1 or 2, and IEN & (FGI|FGO) = 1.
  - While r=1, the counter runs 0,1,2, then returns to 0 and r clears (rule 2 above).
  - SC_CLR still has priority over rule 2.
- Undefined: r is constant 0; IEN, FGI and FGO are ignored. The ports stay in place so the interface is identical.

Decomposition:
- Package mano_pkg holds:
  - default SC_WIDTH, OP_WIDTH and IR_WIDTH constants;
  - IR field-position constants (I bit, opcode MSB);
  - named T and D index constants (T0..T7, D0..D7) used by the control logic.
- Sub-module mano_onehot_dec: parametrised binary-to-one-hot decoder (parameter N input bits, output 2**N lines). It is instantiated twice: once for T from t, once for the opcode ahead of the D register.

Test Plan:
- Reset then free run, no SC_CLR -> t = 0,1,...,15,0. T one-hot each cycle. sc_ovf=1 after the 15->0 step.
- IN_IR=16'h9ABC stable through T2 -> after the T2 edge, D=8'h02 (opcode 1) and i=1. D and i unchanged through T3..T5.
- SC_CLR pulsed at t=5 with START and HLT idle -> t=0 next edge. An HLT pulse at t=3 freezes t=4. SC_CLR while halted -> t=0 and stays 0. START -> t counts again.
- HLT and START asserted together -> run=0.
- With SEQ_INTR_EN, IEN=1, FGI=1 at t=3 -> r=1 next edge. SC_CLR at t=4 -> t=0. The counter then runs 1,2, and on the following edge t=0 and r=0. D and i are unchanged during RT0..RT2.
- RST asserted asynchronously mid-cycle at t=6 with r=1 -> t=0, r=0, D=0, i=0, run=1 immediately, without waiting for a CLK edge.
